// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and state type for the instruction fetch controller
package fetch_pkg;
    localparam int XLEN = 64;
    localparam int ILEN = 32;
    localparam logic [XLEN-1:0] RESET_PC = 64'h0;
    localparam logic [XLEN-1:0] PC_INC = 64'd4;
    typedef enum logic [2:0] {IDLE, REQ, WAIT, DROP, HOLD} state_t;
endpackage

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: single-outstanding instruction fetch FSM with redirect, stall and squash counting
module fetch_ctrl
    import fetch_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            PCWrite,
    input  logic            PCSrc_E,
    input  logic [XLEN-1:0] PC_Target_E,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [ILEN-1:0] imem_rdata,
    output logic            valid_F,
    output logic [XLEN-1:0] PC_F,
    output logic [ILEN-1:0] instr_F,
    output logic [15:0]     squash_cnt
);
    state_t state, state_nx;
    logic [XLEN-1:0] pc_reg, pc_nx;
    logic redirect, capture, squash;
    assign redirect  = PCSrc_E && state != IDLE;
    assign imem_req  = state == REQ;
    assign imem_addr = pc_reg;
    always_comb begin
        state_nx = state;
        pc_nx    = redirect ? (PC_Target_E & ~64'd3) : pc_reg;
        capture  = 1'b0;
        squash   = 1'b0;
        case (state)
            IDLE: state_nx = REQ;
            REQ:  state_nx = imem_ready ? (redirect ? DROP : WAIT) : REQ;
            WAIT: begin
                state_nx = imem_rvalid ? (redirect ? REQ : HOLD) : (redirect ? DROP : WAIT);
                capture  = imem_rvalid && !redirect;
                squash   = imem_rvalid && redirect;
            end
            DROP: begin
                state_nx = imem_rvalid ? REQ : DROP;
                squash   = imem_rvalid;
            end
            HOLD: begin
                state_nx = (redirect || PCWrite) ? REQ : HOLD;
                squash   = redirect;
                if (!redirect && PCWrite) pc_nx = pc_reg + PC_INC;
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pc_reg     <= RESET_PC;
            valid_F    <= 1'b0;
            PC_F       <= '0;
            instr_F    <= '0;
            squash_cnt <= '0;
        end else begin
            state   <= state_nx;
            pc_reg  <= pc_nx;
            valid_F <= state_nx == HOLD;
            if (capture) begin
                PC_F    <= pc_reg;
                instr_F <= imem_rdata;
            end
            if (squash && squash_cnt != 16'hFFFF) squash_cnt <= squash_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed stimulus with a transaction-level model checked every cycle
module tb_fetch_ctrl;
    logic clk = 0, reset = 1, PCWrite = 0, PCSrc_E = 0, imem_ready = 0, imem_rvalid = 0;
    logic [63:0] PC_Target_E = 0;
    logic [31:0] imem_rdata = 0;
    logic imem_req, valid_F;
    logic [63:0] imem_addr, PC_F;
    logic [31:0] instr_F;
    logic [15:0] squash_cnt;
    int total = 0, bad = 0;
    bit mon = 0;
    // model: idle after reset, request outstanding, its response doomed, instruction presented
    bit m_idle = 1, m_out = 0, m_disc = 0, m_have = 0;
    logic [63:0] m_pc = 0, m_pcf = 0;
    logic [31:0] m_ins = 0;
    int m_sq = 0;

    fetch_ctrl dut (
        .clk(clk), .reset(reset), .PCWrite(PCWrite), .PCSrc_E(PCSrc_E), .PC_Target_E(PC_Target_E),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .valid_F(valid_F),
        .PC_F(PC_F), .instr_F(instr_F), .squash_cnt(squash_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic bump();
        m_sq = m_sq < 65535 ? m_sq + 1 : 65535;
    endtask

    task automatic model_step();
        logic [63:0] tgt;
        tgt = PC_Target_E & ~64'd3;
        if (reset) begin
            m_idle = 1; m_out = 0; m_disc = 0; m_have = 0;
            m_pc = 0; m_pcf = 0; m_ins = 0; m_sq = 0;
        end else if (m_idle) begin
            m_idle = 0;
        end else if (m_have) begin
            if (PCSrc_E) begin m_have = 0; m_pc = tgt; bump(); end
            else if (PCWrite) begin m_have = 0; m_pc = m_pc + 64'd4; end
        end else if (!m_out) begin
            if (imem_ready) begin m_out = 1; m_disc = PCSrc_E; end
            if (PCSrc_E) m_pc = tgt;
        end else begin
            if (imem_rvalid) begin
                m_out = 0;
                if (m_disc || PCSrc_E) bump();
                else begin m_have = 1; m_pcf = m_pc; m_ins = imem_rdata; end
                m_disc = 0;
            end else if (PCSrc_E) m_disc = 1;
            if (PCSrc_E) m_pc = tgt;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic fetch(input logic [31:0] d);
        imem_ready = 1; tick(); imem_ready = 0;
        imem_rvalid = 1; imem_rdata = d; tick(); imem_rvalid = 0;
    endtask

    always @(negedge clk) begin
        if (mon) begin
            check("m_req", imem_req, !m_idle && !m_out && !m_have);
            if (!m_idle && !m_out && !m_have) check("m_addr", imem_addr, m_pc);
            check("m_valid", valid_F, m_have);
            if (m_have) begin
                check("m_pcf", PC_F, m_pcf);
                check("m_ins", instr_F, m_ins);
            end
            check("m_sq", squash_cnt, m_sq);
        end
    end

    initial begin
        tick(); mon = 1; tick();
        check("rst_req", imem_req, 0);
        check("rst_valid", valid_F, 0);
        check("rst_sq", squash_cnt, 0);
        check("rst_pcf", PC_F, 0);
        check("rst_ins", instr_F, 0);
        reset = 0; PCSrc_E = 1; PC_Target_E = 64'h300; tick(); PCSrc_E = 0;
        check("idle_redir_addr", imem_addr, 0);
        check("req_on", imem_req, 1);
        fetch(32'h00500093);
        check("f0_valid", valid_F, 1);
        check("f0_pc", PC_F, 0);
        check("f0_ins", instr_F, 32'h00500093);
        PCWrite = 1; tick(); PCWrite = 0;
        check("addr4", imem_addr, 4);
        check("addr4_valid", valid_F, 0);
        fetch(32'h00A00113);
        check("f1_pc", PC_F, 4);
        PCWrite = 1; tick(); PCWrite = 0;
        check("addr8", imem_addr, 8);
        fetch(32'h002081B3);
        repeat (5) begin
            tick();
            check("stall_valid", valid_F, 1);
            check("stall_pc", PC_F, 8);
            check("stall_ins", instr_F, 32'h002081B3);
            check("stall_req", imem_req, 0);
        end
        PCWrite = 1; tick(); PCWrite = 0;
        check("release_addr", imem_addr, 64'hC);
        imem_ready = 1; tick(); imem_ready = 0;
        PCSrc_E = 1; PC_Target_E = 64'h23; tick(); PCSrc_E = 0;
        check("drop_req", imem_req, 0);
        tick();
        imem_rvalid = 1; imem_rdata = 32'hDEADBEEF; tick(); imem_rvalid = 0;
        check("drop_sq", squash_cnt, 1);
        check("drop_addr", imem_addr, 64'h20);
        check("drop_valid", valid_F, 0);
        fetch(32'h00000013);
        check("f3_pc", PC_F, 64'h20);
        PCWrite = 1; PCSrc_E = 1; PC_Target_E = 64'h40; tick(); PCWrite = 0; PCSrc_E = 0;
        check("hold_redir_valid", valid_F, 0);
        check("hold_redir_addr", imem_addr, 64'h40);
        check("hold_redir_sq", squash_cnt, 2);
        imem_rvalid = 1;
        repeat (4) begin
            tick();
            check("nrdy_req", imem_req, 1);
            check("nrdy_addr", imem_addr, 64'h40);
            check("nrdy_valid", valid_F, 0);
        end
        imem_rvalid = 0;
        PCSrc_E = 1; PC_Target_E = 64'h57; tick(); PCSrc_E = 0;
        check("req_redir_addr", imem_addr, 64'h54);
        check("req_redir_sq", squash_cnt, 2);
        imem_ready = 1; tick(); imem_ready = 0;
        reset = 1; tick(); reset = 0;
        check("midrst_req", imem_req, 0);
        check("midrst_valid", valid_F, 0);
        check("midrst_sq", squash_cnt, 0);
        tick();
        check("midrst_addr", imem_addr, 0);
        imem_ready = 1; tick(); imem_ready = 0;
        imem_rvalid = 1; PCSrc_E = 1; PC_Target_E = 64'h100; tick(); imem_rvalid = 0; PCSrc_E = 0;
        check("wait_rv_redir_valid", valid_F, 0);
        check("wait_rv_redir_addr", imem_addr, 64'h100);
        check("wait_rv_redir_sq", squash_cnt, 1);
        imem_ready = 1; PCSrc_E = 1; PC_Target_E = 64'h202; tick(); imem_ready = 0;
        check("req_rdy_redir_req", imem_req, 0);
        PC_Target_E = 64'h300; tick(); PCSrc_E = 0;
        imem_rvalid = 1; tick(); imem_rvalid = 0;
        check("drop_redir_addr", imem_addr, 64'h300);
        check("drop_redir_sq", squash_cnt, 2);
        PCSrc_E = 1; PC_Target_E = '1; tick(); PCSrc_E = 0;
        check("wrap_addr", imem_addr, 64'hFFFFFFFFFFFFFFFC);
        fetch(32'h00000013);
        check("wrap_pcf", PC_F, 64'hFFFFFFFFFFFFFFFC);
        PCWrite = 1; tick(); PCWrite = 0;
        check("wrap_next", imem_addr, 0);
        repeat (65540) begin
            imem_ready = 1; tick(); imem_ready = 0;
            imem_rvalid = 1; PCSrc_E = 1; PC_Target_E = 0; tick();
            imem_rvalid = 0; PCSrc_E = 0;
        end
        check("sat_sq", squash_cnt, 16'hFFFF);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
